// File: rtl/swerv_trace_fifo_if.sv
// Record stream from the trace FIFO to the SoC trace sink (UART / debug capture).
// The FIFO drives the record and out_valid; the sink answers with out_ready.
interface swerv_trace_fifo_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic [31:0] out_addr;
  logic [1:0]  out_slot;
  logic        out_exception;
  logic        out_interrupt;
  logic [4:0]  out_ecause;
  logic [31:0] out_tval;

  modport master (
    output out_valid, out_insn, out_addr, out_slot,
           out_exception, out_interrupt, out_ecause, out_tval,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_insn, out_addr, out_slot,
           out_exception, out_interrupt, out_ecause, out_tval,
    output out_ready
  );
endinterface

// File: rtl/swerv_trace_fifo.sv
// Splits a 3-lane retirement trace bundle into single-instruction records, buffers them
// in a circular FIFO and streams one record per cycle. Packets that do not fit are dropped whole.
module swerv_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               trace_rv_i_valid_ip,
  input  logic [95:0]              trace_rv_i_insn_ip,
  input  logic [95:0]              trace_rv_i_address_ip,
  input  logic [2:0]               trace_rv_i_exception_ip,
  input  logic [4:0]               trace_rv_i_ecause_ip,
  input  logic [2:0]               trace_rv_i_interrupt_ip,
  input  logic [31:0]              trace_rv_i_tval_ip,
  swerv_trace_fifo_if.master       trace_out,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     ovf_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] addr;
    logic [1:0]  slot;
    logic        exception;
    logic        interrupt;
    logic [4:0]  ecause;
    logic [31:0] tval;
  } rec_t;

  rec_t          mem [DEPTH];
  rec_t          head;
  logic [PW-1:0] wptr, rptr;
  logic [1:0]    lane_off [3];
  logic [1:0]    n;
  logic [LW-1:0] free_cnt, push_cnt;
  logic          accept, drop, pop;

  // Each valid lane lands at wptr plus the number of valid lanes below it, so no holes appear.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    lane_off[0] = 2'd0;
    lane_off[1] = {1'b0, trace_rv_i_valid_ip[0]};
    lane_off[2] = 2'({1'b0, trace_rv_i_valid_ip[0]} + {1'b0, trace_rv_i_valid_ip[1]});
    n           = 2'(lane_off[2] + {1'b0, trace_rv_i_valid_ip[2]});
    free_cnt    = DEPTH_L - level;
    accept      = (n != 2'd0) && (free_cnt >= LW'(n));
    drop        = (n != 2'd0) && !accept;
    pop         = trace_out.out_valid && trace_out.out_ready;
    push_cnt    = accept ? LW'(n) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (accept) wptr <= wptr + PW'(n);
      if (pop)    rptr <= rptr + PW'(1);
      level <= level + push_cnt - LW'(pop);
      // A clear wins over a same-cycle drop; that drop is deliberately not counted.
      if (ovf_clr) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  // NOTE: the storage array has no reset; level alone says which entries are meaningful.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < 3; k++) begin
        if (trace_rv_i_valid_ip[k]) begin
          mem[wptr + PW'(lane_off[k])] <= '{
            insn:      trace_rv_i_insn_ip[32*k +: 32],
            addr:      trace_rv_i_address_ip[32*k +: 32],
            slot:      2'(k),
            exception: trace_rv_i_exception_ip[k],
            interrupt: trace_rv_i_interrupt_ip[k],
            ecause:    trace_rv_i_ecause_ip,
            tval:      trace_rv_i_tval_ip
          };
        end
      end
    end
  end

  // Head is masked while empty so the data fields read zero through reset and idle periods.
  always_comb begin
    head = (level != '0) ? mem[rptr] : '0;
  end

  assign trace_out.out_valid     = (level != '0);
  assign trace_out.out_insn      = head.insn;
  assign trace_out.out_addr      = head.addr;
  assign trace_out.out_slot      = head.slot;
  assign trace_out.out_exception = head.exception;
  assign trace_out.out_interrupt = head.interrupt;
  assign trace_out.out_ecause    = head.ecause;
  assign trace_out.out_tval      = head.tval;

endmodule
